// File: rtl/lw_sha_ahb_ingress_pkg.sv
// Shared definitions for the SHA/HMAC AHB ingress block.
// Contents: register offsets, CTRL/STATUS/IRQ_EN bit indices, HTRANS encodings,
//           register-select and error-FSM enums, address decode and hsize check.
package lw_sha_ahb_pkg;

   // Register offsets (byte addresses)
   localparam logic [31:0] OFS_CTRL   = 32'h000;
   localparam logic [31:0] OFS_STATUS = 32'h004;
   localparam logic [31:0] OFS_DATA   = 32'h008;
   localparam logic [31:0] OFS_IRQ_EN = 32'h00C;

   // CTRL bits
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_LAST  = 2;

   // STATUS bits ([7:0] is the FIFO count)
   localparam int STAT_OVF  = 8;
   localparam int STAT_PART = 9;

   // IRQ_EN bits
   localparam int IRQ_IDLE = 0;
   localparam int IRQ_OVF  = 1;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      REG_CTRL   = 3'd0,
      REG_STATUS = 3'd1,
      REG_DATA   = 3'd2,
      REG_IRQ_EN = 3'd3,
      REG_NONE   = 3'd4
   } reg_sel_t;

   typedef enum logic [1:0] {
      ST_OKAY = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } err_state_t;

   function automatic reg_sel_t reg_decode(input logic [31:0] addr);
      reg_sel_t sel;
      case (addr)
         OFS_CTRL:   sel = REG_CTRL;
         OFS_STATUS: sel = REG_STATUS;
         OFS_DATA:   sel = REG_DATA;
         OFS_IRQ_EN: sel = REG_IRQ_EN;
         default:    sel = REG_NONE;
      endcase
      return sel;
   endfunction

   // Only full-width transfers are legal.
   function automatic logic hsize_ok(input logic [2:0] hsize, input int bus_w);
      return hsize == 3'($clog2(bus_w / 8));
   endfunction

endpackage

// File: rtl/lw_sha_ahb_ingress_if.sv
// AHB-Lite slave-side bus bundle for the SHA ingress block.
// master: haddr/hsize/htrans/hwrite/hwdata plus the interconnect's hready.
// slave : hrdata/hreadyout/hresp back to the interconnect.
interface lw_sha_ahb_ingress_if #(
   parameter int BUS_W  = 32,
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] haddr;
   logic [2:0]        hsize;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [BUS_W-1:0]  hwdata;
   logic              hready;     // interconnect-level ready, grouped with the request side
   logic [BUS_W-1:0]  hrdata;
   logic              hreadyout;
   logic              hresp;

   modport master (
      output haddr, hsize, htrans, hwrite, hwdata, hready,
      input  hrdata, hreadyout, hresp
   );

   modport slave (
      input  haddr, hsize, htrans, hwrite, hwdata, hready,
      output hrdata, hreadyout, hresp
   );
endinterface

// File: rtl/lw_sha_ahb_ingress_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and synchronous clear.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module lw_sha_sync_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
   assign do_push = push & (~full | do_pop);

   // Head is forced to zero when empty so the stream port never shows stale data.
   assign head_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clr) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/lw_sha_ahb_ingress.sv
// AHB-Lite slave that packs DATA beats into core words, buffers them and streams them to the hash core.
// Latency: a completing beat's word shows on valid_o/data_o one cycle after its data phase; reads have zero wait states.
// Backpressure: full FIFO either stalls the bus (STALL_EN=1) or drops the word and flags overflow (STALL_EN=0).
// Ports: hclk/hreset; bus (AHB slave modport); data_o/valid_o/ready_i/last_o core stream;
//        start_o/abort_o pulses; irq_o level interrupt; dma_wr_req_o free-slot indication.
module lw_sha_ahb_ingress
   import lw_sha_ahb_pkg::*;
#(
   parameter int BUS_W    = 32,
   parameter int CORE_W   = 64,
   parameter int DEPTH    = 4,
   parameter int ADDR_W   = 12,
   parameter bit STALL_EN = 1'b1
) (
   input  logic                hclk,
   input  logic                hreset,
   lw_sha_ahb_ingress_if.slave bus,
   output logic [CORE_W-1:0]   data_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                last_o,
   output logic                start_o,
   output logic                abort_o,
   output logic                irq_o,
   output logic                dma_wr_req_o
);
   localparam int RATIO = CORE_W / BUS_W;
   localparam int PCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int CW    = $clog2(DEPTH) + 1;

   // ---------------- address phase ----------------
   logic       ap_xfer;
   logic       ap_err;
   logic       capture_err;
   reg_sel_t   ap_sel;

   logic       dp_vld;
   logic       dp_write;
   reg_sel_t   dp_sel;

   assign ap_xfer     = (bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ);
   assign ap_sel      = reg_decode(32'(bus.haddr));
   assign ap_err      = (ap_sel == REG_NONE) | ~hsize_ok(bus.hsize, BUS_W);
   assign capture_err = bus.hready & ap_xfer & ap_err;

   // Erroring transfers never reach the data phase, which is what keeps them side-effect free.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         dp_vld   <= 1'b0;
         dp_write <= 1'b0;
         dp_sel   <= REG_NONE;
      end else if (bus.hready) begin
         dp_vld   <= ap_xfer & ~ap_err;
         dp_write <= bus.hwrite;
         dp_sel   <= ap_sel;
      end
   end

   // ---------------- FIFO / packer status ----------------
   logic [PCW-1:0]    pack_cnt;
   logic [CORE_W-1:0] pack_buf;
   logic [CORE_W-1:0] word_next;
   logic              last_pend;
   logic              overflow;
   logic [1:0]        irq_en;
   logic [CW-1:0]     count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CORE_W:0]   head;
   logic              partial;

   logic data_beat;
   logic beat_last;
   logic pop;
   logic blocked;
   logic stall;
   logic wr_done;
   logic beat_fire;
   logic push;
   logic drop;
   logic ctrl_wr;
   logic start_wr;
   logic abort_wr;
   logic last_set;
   logic ovf_clr;
   logic irq_wr;

   assign valid_o   = ~fifo_empty;
   assign pop       = valid_o & ready_i;
   assign partial   = (pack_cnt != '0);

   assign data_beat = dp_vld & dp_write & (dp_sel == REG_DATA);
   assign beat_last = (pack_cnt == PCW'(RATIO - 1));
   // A pop in the same cycle frees the slot, so only a full FIFO with no pop blocks.
   assign blocked   = data_beat & beat_last & fifo_full & ~pop;
   assign stall     = STALL_EN & blocked;

   assign wr_done   = dp_vld & dp_write & ~stall;
   assign beat_fire = data_beat & ~stall;
   assign push      = beat_fire & beat_last & ~blocked;
   assign drop      = beat_fire & beat_last & blocked;

   assign ctrl_wr   = wr_done & (dp_sel == REG_CTRL);
   assign start_wr  = ctrl_wr & bus.hwdata[CTRL_START];
   assign abort_wr  = ctrl_wr & bus.hwdata[CTRL_ABORT];
   assign last_set  = ctrl_wr & bus.hwdata[CTRL_LAST];
   assign ovf_clr   = wr_done & (dp_sel == REG_STATUS) & bus.hwdata[STAT_OVF];
   assign irq_wr    = wr_done & (dp_sel == REG_IRQ_EN);

   // Little-endian lane fill: beat n lands in bits [n*BUS_W +: BUS_W].
   always_comb begin
      word_next = pack_buf;
      word_next[pack_cnt*BUS_W +: BUS_W] = bus.hwdata;
   end

   // ---------------- error FSM ----------------
   err_state_t state;
   err_state_t state_nxt;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) state <= ST_OKAY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_OKAY: if (capture_err) state_nxt = ST_ERR1;
         ST_ERR1: state_nxt = ST_ERR2;
         // ERR2 drives hreadyout high, so a back-to-back erroring transfer can be taken here.
         ST_ERR2: state_nxt = capture_err ? ST_ERR1 : ST_OKAY;
         default: state_nxt = ST_OKAY;
      endcase
   end

   always_comb begin
      bus.hreadyout = 1'b1;
      bus.hresp     = 1'b0;
      case (state)
         ST_OKAY: bus.hreadyout = ~stall;
         ST_ERR1: begin
            bus.hreadyout = 1'b0;
            bus.hresp     = 1'b1;
         end
         ST_ERR2: bus.hresp = 1'b1;
         default: ;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         start_o <= 1'b0;
         abort_o <= 1'b0;
      end else begin
         start_o <= start_wr;
         abort_o <= abort_wr;
      end
   end

   // Abort wins over everything else in the packer; the FIFO clears on the same edge.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         pack_cnt  <= '0;
         pack_buf  <= '0;
         last_pend <= 1'b0;
      end else if (abort_wr) begin
         pack_cnt  <= '0;
         pack_buf  <= '0;
         last_pend <= 1'b0;
      end else begin
         if (last_set) last_pend <= 1'b1;
         if (beat_fire) begin
            if (beat_last) begin
               // last_pend is consumed whether the word was stored or dropped.
               pack_cnt  <= '0;
               pack_buf  <= '0;
               last_pend <= 1'b0;
            end else begin
               pack_cnt <= pack_cnt + 1'b1;
               pack_buf <= word_next;
            end
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)        overflow <= 1'b0;
      else if (abort_wr) overflow <= 1'b0;
      else if (drop)     overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)      irq_en <= 2'b00;
      else if (irq_wr) irq_en <= bus.hwdata[1:0];
   end

   // ---------------- FIFO ----------------
   lw_sha_sync_fifo #(
      .W     (CORE_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (hclk),
      .rst      (hreset),
      .clr      (abort_wr),
      .push     (push),
      .push_dat ({last_pend, word_next}),
      .pop      (pop),
      .head_dat (head),
      .count    (count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign data_o = head[CORE_W-1:0];
   assign last_o = head[CORE_W];

   // ---------------- read data and status outputs ----------------
   always_comb begin
      bus.hrdata = '0;
      if (dp_vld && !dp_write) begin
         case (dp_sel)
            REG_STATUS: begin
               bus.hrdata[7:0]       = 8'(count);
               bus.hrdata[STAT_OVF]  = overflow;
               bus.hrdata[STAT_PART] = partial;
            end
            REG_IRQ_EN: bus.hrdata[1:0] = irq_en;
            default: ;
         endcase
      end
   end

   assign irq_o = (irq_en[IRQ_IDLE] & fifo_empty & ~partial) | (irq_en[IRQ_OVF] & overflow);
   // Held low while reset is applied so every output except hreadyout reads 0 in reset.
   assign dma_wr_req_o = ~hreset & ~fifo_full;

endmodule

// File: tb/tb_lw_sha_ahb_ingress.sv
// Directed bench for lw_sha_ahb_ingress: one stalling instance and one dropping instance
// share a single AHB master; the unselected instance sees IDLE transfers.
module tb_lw_sha_ahb_ingress;
   logic hclk = 1'b0;
   logic hreset;
   always #5 hclk = ~hclk;

   int n_chk  = 0;
   int n_fail = 0;

   logic        sel;      // 0 = stalling instance, 1 = dropping instance
   logic [11:0] m_haddr;
   logic [2:0]  m_hsize;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [31:0] m_hwdata;
   logic        ready_s;
   logic        ready_d;

   lw_sha_ahb_ingress_if #(.BUS_W(32), .ADDR_W(12)) bus_s ();
   lw_sha_ahb_ingress_if #(.BUS_W(32), .ADDR_W(12)) bus_d ();

   assign bus_s.haddr  = m_haddr;
   assign bus_s.hsize  = m_hsize;
   assign bus_s.hwrite = m_hwrite;
   assign bus_s.hwdata = m_hwdata;
   assign bus_s.htrans = (sel == 1'b0) ? m_htrans : 2'b00;
   assign bus_s.hready = bus_s.hreadyout;
   assign bus_d.haddr  = m_haddr;
   assign bus_d.hsize  = m_hsize;
   assign bus_d.hwrite = m_hwrite;
   assign bus_d.hwdata = m_hwdata;
   assign bus_d.htrans = (sel == 1'b1) ? m_htrans : 2'b00;
   assign bus_d.hready = bus_d.hreadyout;

   logic [63:0] s_data, d_data;
   logic s_valid, s_last, s_start, s_abort, s_irq, s_dma;
   logic d_valid, d_last, d_start, d_abort, d_irq, d_dma;

   lw_sha_ahb_ingress #(.BUS_W(32), .CORE_W(64), .DEPTH(4), .ADDR_W(12), .STALL_EN(1'b1)) dut_s (
      .hclk(hclk), .hreset(hreset), .bus(bus_s),
      .data_o(s_data), .valid_o(s_valid), .ready_i(ready_s), .last_o(s_last),
      .start_o(s_start), .abort_o(s_abort), .irq_o(s_irq), .dma_wr_req_o(s_dma)
   );

   lw_sha_ahb_ingress #(.BUS_W(32), .CORE_W(64), .DEPTH(4), .ADDR_W(12), .STALL_EN(1'b0)) dut_d (
      .hclk(hclk), .hreset(hreset), .bus(bus_d),
      .data_o(d_data), .valid_o(d_valid), .ready_i(ready_d), .last_o(d_last),
      .start_o(d_start), .abort_o(d_abort), .irq_o(d_irq), .dma_wr_req_o(d_dma)
   );

   wire        cur_rdy   = sel ? bus_d.hreadyout : bus_s.hreadyout;
   wire        cur_resp  = sel ? bus_d.hresp     : bus_s.hresp;
   wire [31:0] cur_rdata = sel ? bus_d.hrdata    : bus_s.hrdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the selected slave ready; returns at the negedge inside the data phase.
   task automatic addr_phase(input logic [11:0] a, input logic w, input logic [2:0] sz);
      m_haddr  = a;
      m_hwrite = w;
      m_hsize  = sz;
      m_htrans = 2'b10;
      @(negedge hclk);
      m_htrans = 2'b00;
   endtask

   task automatic wr_start(input logic [11:0] a, input logic [31:0] d);
      addr_phase(a, 1'b1, 3'd2);
      m_hwdata = d;
   endtask

   task automatic wr_finish();
      int n = 0;
      while (!cur_rdy && n < 50) begin
         @(negedge hclk);
         n++;
      end
      if (n >= 50) chk("hreadyout_timeout", {63'd0, cur_rdy}, 64'd1);
      @(negedge hclk);
   endtask

   task automatic ahb_wr(input logic [11:0] a, input logic [31:0] d);
      wr_start(a, d);
      wr_finish();
   endtask

   task automatic ahb_rd(input logic [11:0] a, output logic [31:0] d);
      addr_phase(a, 1'b0, 3'd2);
      d = cur_rdata;
      @(negedge hclk);
   endtask

   task automatic err_xfer(input string tag, input logic [11:0] a, input logic w, input logic [2:0] sz);
      addr_phase(a, w, sz);
      m_hwdata = 32'h0000_0107;
      chk({tag, "_c1_rdy"}, cur_rdy, 1'b0);
      chk({tag, "_c1_resp"}, cur_resp, 1'b1);
      @(negedge hclk);
      chk({tag, "_c2_rdy"}, cur_rdy, 1'b1);
      chk({tag, "_c2_resp"}, cur_resp, 1'b1);
      @(negedge hclk);
      chk({tag, "_after_resp"}, cur_resp, 1'b0);
   endtask

   task automatic pop_s();
      ready_s = 1'b1;
      @(negedge hclk);
      ready_s = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      sel = 1'b0; m_haddr = '0; m_hsize = 3'd2; m_htrans = 2'b00; m_hwrite = 1'b0; m_hwdata = '0;
      ready_s = 1'b0; ready_d = 1'b0;
      hreset = 1'b1;
      repeat (2) @(negedge hclk);

      // Reset state
      chk("rst_hreadyout", bus_s.hreadyout, 1'b1);
      chk("rst_hresp", bus_s.hresp, 1'b0);
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_data", s_data, 64'd0);
      chk("rst_last", s_last, 1'b0);
      chk("rst_start_abort", {s_start, s_abort}, 2'b00);
      chk("rst_irq", s_irq, 1'b0);
      chk("rst_dma", s_dma, 1'b0);
      chk("rst_d_outputs", {d_valid, d_irq, d_dma, bus_d.hreadyout}, 4'b0001);
      hreset = 1'b0;
      @(negedge hclk);
      chk("dma_after_rst", s_dma, 1'b1);

      // Packing and push-to-valid latency
      ahb_wr(12'h008, 32'h1111_1111);
      chk("pack_beat1_novalid", s_valid, 1'b0);
      wr_start(12'h008, 32'h2222_2222);
      chk("pack_dphase_novalid", s_valid, 1'b0);
      chk("pack_dphase_rdy", bus_s.hreadyout, 1'b1);
      wr_finish();
      chk("pack_valid", s_valid, 1'b1);
      chk("pack_data", s_data, 64'h2222_2222_1111_1111);
      chk("pack_last", s_last, 1'b0);
      ahb_rd(12'h004, rd);
      chk("pack_status", rd, 32'h0000_0001);

      // Error responses leave state untouched
      err_xfer("err_hsize", 12'h008, 1'b1, 3'd1);
      err_xfer("err_addr", 12'h010, 1'b0, 3'd2);
      ahb_rd(12'h004, rd);
      chk("err_status_same", rd, 32'h0000_0001);
      chk("err_data_same", s_data, 64'h2222_2222_1111_1111);
      ahb_rd(12'h000, rd);
      chk("rd_ctrl_zero", rd, 32'd0);

      pop_s();
      chk("pop_empty", s_valid, 1'b0);

      // Start pulse
      ahb_wr(12'h000, 32'h1);
      chk("start_pulse", {s_start, s_abort}, 2'b10);
      @(negedge hclk);
      chk("start_pulse_end", s_start, 1'b0);

      // Last flag
      ahb_wr(12'h000, 32'h4);
      ahb_wr(12'h008, 32'h0000_000A);
      ahb_wr(12'h008, 32'h0000_000B);
      chk("last_word_flag", s_last, 1'b1);
      chk("last_word_data", s_data, 64'h0000_000B_0000_000A);
      ahb_wr(12'h008, 32'h0000_000C);
      ahb_wr(12'h008, 32'h0000_000D);
      pop_s();
      chk("next_word_data", s_data, 64'h0000_000D_0000_000C);
      chk("next_word_last", s_last, 1'b0);
      pop_s();

      // Idle interrupt and partial flag
      ahb_wr(12'h00C, 32'h1);
      chk("irq_idle", s_irq, 1'b1);
      ahb_rd(12'h00C, rd);
      chk("irq_en_rd", rd, 32'h1);
      ahb_wr(12'h008, 32'h55);
      chk("irq_idle_partial", s_irq, 1'b0);
      ahb_rd(12'h004, rd);
      chk("status_partial", rd, 32'h0000_0200);

      // Abort with one partial beat and two buffered words
      ahb_wr(12'h008, 32'h66);
      ahb_wr(12'h008, 32'h77);
      ahb_wr(12'h008, 32'h88);
      ahb_wr(12'h008, 32'h99);
      ahb_rd(12'h004, rd);
      chk("pre_abort_status", rd, 32'h0000_0202);
      ahb_wr(12'h000, 32'h2);
      chk("abort_pulse", s_abort, 1'b1);
      chk("abort_valid", s_valid, 1'b0);
      ahb_rd(12'h004, rd);
      chk("abort_status", rd, 32'h0);
      chk("abort_pulse_end", s_abort, 1'b0);
      chk("abort_irq_idle", s_irq, 1'b1);
      ahb_wr(12'h00C, 32'h0);

      // Stall on full
      for (int i = 1; i <= 9; i++) ahb_wr(12'h008, 32'(i));
      chk("full_dma", s_dma, 1'b0);
      wr_start(12'h008, 32'd10);
      chk("stall_rdy", bus_s.hreadyout, 1'b0);
      chk("stall_resp", bus_s.hresp, 1'b0);
      @(negedge hclk);
      chk("stall_rdy_held", bus_s.hreadyout, 1'b0);
      ready_s = 1'b1;
      #1;
      chk("stall_release_rdy", bus_s.hreadyout, 1'b1);
      @(negedge hclk);
      ready_s = 1'b0;
      ahb_rd(12'h004, rd);
      chk("stall_count", rd, 32'h0000_0004);
      chk("stall_head", s_data, 64'h0000_0004_0000_0003);

      // Overflow drop on the non-stalling instance
      sel = 1'b1;
      ahb_wr(12'h00C, 32'h2);
      chk("ovf_irq_pre", d_irq, 1'b0);
      for (int i = 1; i <= 9; i++) ahb_wr(12'h008, 32'(i));
      wr_start(12'h008, 32'd10);
      chk("drop_no_stall", bus_d.hreadyout, 1'b1);
      wr_finish();
      ahb_rd(12'h004, rd);
      chk("ovf_status", rd, 32'h0000_0104);
      chk("ovf_irq", d_irq, 1'b1);
      chk("ovf_head", d_data, 64'h0000_0002_0000_0001);
      ahb_wr(12'h004, 32'h100);
      ahb_rd(12'h004, rd);
      chk("ovf_clear_status", rd, 32'h0000_0004);
      chk("ovf_clear_irq", d_irq, 1'b0);

      // Reset while a stalled beat is in its data phase
      sel = 1'b0;
      ahb_wr(12'h008, 32'h77);
      wr_start(12'h008, 32'h88);
      chk("rst_mid_stall", bus_s.hreadyout, 1'b0);
      hreset = 1'b1;
      #1;
      chk("rst_mid_rdy", bus_s.hreadyout, 1'b1);
      chk("rst_mid_valid", s_valid, 1'b0);
      @(negedge hclk);
      hreset = 1'b0;
      @(negedge hclk);
      ahb_rd(12'h004, rd);
      chk("rst_mid_status", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
